// File: rtl/mac_accumulator_if.sv
// Product-in / result-out handshake bundle for one mac_accumulator lane.
// master = upstream multiplier + downstream consumer side, slave = accumulator.
interface mac_accumulator_if #(
    parameter int IN_WIDTH  = 32,
    parameter int LEN_WIDTH = 8,
    parameter int OUT_WIDTH = 16
);
    logic                 start;
    logic [LEN_WIDTH-1:0] len;
    logic                 prod_valid;
    logic [IN_WIDTH-1:0]  prod;
    logic                 prod_ready;
    logic                 result_valid;
    logic                 result_ready;
    logic [OUT_WIDTH-1:0] result;
    logic                 busy;
    logic                 overflow;

    modport master (
        output start, len, prod_valid, prod, result_ready,
        input  prod_ready, result_valid, result, busy, overflow
    );

    modport slave (
        input  start, len, prod_valid, prod, result_ready,
        output prod_ready, result_valid, result, busy, overflow
    );
endinterface

// File: rtl/mac_accumulator.sv
// Sums a programmed number of signed products into a wide accumulator and
// hands one saturated result word downstream over valid/ready.
module mac_accumulator #(
    parameter int IN_WIDTH  = 32,
    parameter int LEN_WIDTH = 8,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 16
) (
    input logic              clk,
    input logic              arst_n_in,
    mac_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   count_q, count_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [OUT_WIDTH-1:0]   result_q, result_d;
    logic                   ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   sum;
    logic [ACC_WIDTH-OUT_WIDTH:0] sum_hi;
    logic                   clip;
    logic [OUT_WIDTH-1:0]   sat;

    assign prod_ext = {{(ACC_WIDTH-IN_WIDTH){bus.prod[IN_WIDTH-1]}}, bus.prod};
    assign sum      = acc_q + prod_ext;

    // The sum fits in OUT_WIDTH exactly when every bit from the output sign
    // bit upward is a copy of the accumulator sign bit.
    assign sum_hi = sum[ACC_WIDTH-1:OUT_WIDTH-1];
    assign clip   = !((&sum_hi) || (~|sum_hi));
    assign sat    = !clip            ? sum[OUT_WIDTH-1:0] :
                    sum[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                       {1'b0, {(OUT_WIDTH-1){1'b1}}};

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            count_q  <= '0;
            len_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            len_q    <= len_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        len_d    = len_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (bus.len == '0) begin
                        result_d = '0;
                        state_d  = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // prod_ready is high throughout ACCUM, so prod_valid alone is a transfer.
                if (bus.prod_valid) begin
                    acc_d   = sum;
                    count_d = count_q + LEN_WIDTH'(1);
                    if (count_q == len_q - LEN_WIDTH'(1)) begin
                        result_d = sat;
                        ovf_d    = clip;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.prod_ready   = (state_q == ACCUM);
    assign bus.result_valid = (state_q == HOLD);
    assign bus.busy         = (state_q != IDLE);
    assign bus.result       = result_q;
    assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed scoreboard bench for mac_accumulator: expected sums are queued
// when products are driven and compared when the result is presented.
module tb_mac_accumulator;

    localparam int IN_WIDTH  = 32;
    localparam int LEN_WIDTH = 8;
    localparam int ACC_WIDTH = 40;
    localparam int OUT_WIDTH = 16;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] r;
        logic                 ov;
    } exp_t;

    logic clk;
    logic arst_n;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    int   prods[$];
    bit   vpat[$];

    mac_accumulator_if #(
        .IN_WIDTH (IN_WIDTH),
        .LEN_WIDTH(LEN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) bus ();

    mac_accumulator #(
        .IN_WIDTH (IN_WIDTH),
        .LEN_WIDTH(LEN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .arst_n_in(arst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start/len, then walks vpat presenting prods on valid slots and
    // junk on bubble slots; queues the saturated expected sum if push is set.
    task automatic feed(input int l, input bit push);
        longint s;
        int     k;
        exp_t   e;
        s = 0;
        k = 0;
        bus.start = 1'b1;
        bus.len   = l[7:0];
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'(1));
        check("prod_ready_after_start", 64'(bus.prod_ready), 64'(l != 0));
        for (int i = 0; i < vpat.size(); i++) begin
            if (vpat[i]) begin
                bus.prod_valid = 1'b1;
                bus.prod       = prods[k];
                s += prods[k];
                k++;
            end else begin
                bus.prod_valid = 1'b0;
                bus.prod       = 32'h0BAD_F00D;
            end
            if (i == vpat.size() - 1) begin
                check("rv_before_last", 64'(bus.result_valid), 64'(0));
            end
            tick();
        end
        bus.prod_valid = 1'b0;
        if (s > 32767) begin
            e.r  = 16'h7FFF;
            e.ov = 1'b1;
        end else if (s < -32768) begin
            e.r  = 16'h8000;
            e.ov = 1'b1;
        end else begin
            e.r  = s[15:0];
            e.ov = 1'b0;
        end
        if (push) sb.push_back(e);
    endtask

    task automatic collect();
        int   waited;
        exp_t e;
        waited = 0;
        while (!bus.result_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("rv_latency", 64'(waited), 64'(0));
        check("rv_present", 64'(bus.result_valid), 64'(1));
        check("sb_nonempty", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result", 64'(bus.result), 64'(e.r));
            check("overflow", 64'(bus.overflow), 64'(e.ov));
            check("prod_ready_hold", 64'(bus.prod_ready), 64'(0));
            bus.result_ready = 1'b1;
            tick();
            bus.result_ready = 1'b0;
            check("rv_after_ack", 64'(bus.result_valid), 64'(0));
            check("busy_after_ack", 64'(bus.busy), 64'(0));
            check("result_kept", 64'(bus.result), 64'(e.r));
            check("overflow_sticky", 64'(bus.overflow), 64'(e.ov));
        end
    endtask

    initial begin
        exp_t held;
        n_tests = 0;
        n_fail  = 0;
        arst_n  = 1'b0;
        bus.start        = 1'b0;
        bus.len          = '0;
        bus.prod_valid   = 1'b0;
        bus.prod         = '0;
        bus.result_ready = 1'b0;
        #3;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_prod_ready", 64'(bus.prod_ready), 64'(0));
        check("rst_rv", 64'(bus.result_valid), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        check("rst_overflow", 64'(bus.overflow), 64'(0));
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        // basic 4-term sum, back-to-back products
        prods = '{3, -5, 7, 10};
        vpat  = '{1, 1, 1, 1};
        feed(4, 1'b1);
        collect();

        // bubbles on prod_valid; junk during bubbles must not be summed
        prods = '{100, 200, 300};
        vpat  = '{1, 0, 0, 1, 0, 1};
        feed(3, 1'b1);
        collect();

        // positive clip, negative clip, then clean sum clears overflow
        prods = '{20000, 20000, 20000, 20000};
        vpat  = '{1, 1, 1, 1};
        feed(4, 1'b1);
        collect();
        prods = '{-20000, -20000};
        vpat  = '{1, 1};
        feed(2, 1'b1);
        collect();
        prods = '{5};
        vpat  = '{1};
        feed(1, 1'b1);
        collect();

        // len=0 with prod_valid held high: straight to HOLD with zero
        bus.prod_valid = 1'b1;
        bus.prod       = 32'd55;
        prods = {};
        vpat  = {};
        feed(0, 1'b1);
        bus.prod_valid = 1'b1;
        collect();
        bus.prod_valid = 1'b0;

        // HOLD stalled with start and prod_valid asserted
        prods = '{7};
        vpat  = '{1};
        feed(1, 1'b1);
        held = sb.pop_front();
        bus.start      = 1'b1;
        bus.len        = 8'd3;
        bus.prod_valid = 1'b1;
        bus.prod       = 32'd1234;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_rv", 64'(bus.result_valid), 64'(1));
            check("stall_result", 64'(bus.result), 64'(held.r));
            check("stall_prod_ready", 64'(bus.prod_ready), 64'(0));
        end
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        bus.prod_valid   = 1'b0;
        check("start_ignored_in_hold", 64'(bus.busy), 64'(0));
        prods = '{42};
        vpat  = '{1};
        feed(1, 1'b1);
        collect();

        // reset after 2 of 5 products discards the partial sum
        prods = '{9, 9};
        vpat  = '{1, 1};
        feed(5, 1'b0);
        arst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_prod_ready", 64'(bus.prod_ready), 64'(0));
        check("abort_rv", 64'(bus.result_valid), 64'(0));
        check("abort_result", 64'(bus.result), 64'(0));
        check("abort_overflow", 64'(bus.overflow), 64'(0));
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        prods = '{1, 1};
        vpat  = '{1, 1};
        feed(2, 1'b1);
        collect();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
